// File: rtl/kn_pkg.sv
// rtl/kn_pkg.sv - shared constants and width helpers for the KN FIFO bank
package kn_pkg;

  localparam int unsigned KN_NUM_PES   = 16;
  localparam int unsigned KN_DATA_TYPE = 16;
  localparam int unsigned KN_ROW_W     = KN_DATA_TYPE * KN_NUM_PES;

  function automatic int unsigned row_width(input int unsigned data_type,
                                            input int unsigned num_pes);
    return data_type * num_pes;
  endfunction

  // Occupancy needs one bit more than the pointers so that 0..DEPTH fits.
  function automatic int unsigned fill_width(input int unsigned log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/kn_fifo_slice.sv
// rtl/kn_fifo_slice.sv - one first-word-fall-through KN row FIFO with occupancy count
module kn_fifo_slice
  import kn_pkg::*;
#(
  parameter int unsigned W          = 256,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LOG2_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [W-1:0]                         wr_data,
  input  logic                                 pop,
  output logic [W-1:0]                         rd_data,
  output logic                                 empty,
  output logic                                 full,
  output logic [fill_width(LOG2_DEPTH)-1:0]    count
);

  localparam int unsigned CW = fill_width(LOG2_DEPTH);

  logic [W-1:0]          mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Empty slices read as zero so downstream never sees stale rows.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kn_fifo_bank.sv
// rtl/kn_fifo_bank.sv - round-robin bank of KN FIFOs; optional o_err via KN_FIFO_BANK_ERR_EN
module kn_fifo_bank
  import kn_pkg::*;
#(
  parameter int unsigned NUM_PES          = 16,
  parameter int unsigned DATA_TYPE        = 16,
  parameter int unsigned PARA_BLOCKS      = 4,
  parameter int unsigned LOG2_PARA_BLOCKS = 2,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned LOG2_DEPTH       = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_kn_valid,
  input  logic [DATA_TYPE*NUM_PES-1:0]                 i_kn_data,
  input  logic                                         i_kn_last,
  output logic                                         o_kn_ready,
  input  logic [PARA_BLOCKS-1:0]                       i_fifo_KN_rd_en,
  output logic [PARA_BLOCKS*DATA_TYPE*NUM_PES-1:0]     o_fifo_KN_data_out,
  output logic                                         o_fifo_KN_data_empty,
`ifdef KN_FIFO_BANK_ERR_EN
  output logic [PARA_BLOCKS*(LOG2_DEPTH+1)-1:0]        o_fill_level,
  output logic [1:0]                                   o_err
`else
  output logic [PARA_BLOCKS*(LOG2_DEPTH+1)-1:0]        o_fill_level
`endif
);

  localparam int unsigned ROW_W = row_width(DATA_TYPE, NUM_PES);
  localparam int unsigned FW    = fill_width(LOG2_DEPTH);

  logic [LOG2_PARA_BLOCKS-1:0] wr_blk;
  logic [PARA_BLOCKS-1:0]      push_vec;
  logic [PARA_BLOCKS-1:0]      empty_vec;
  logic [PARA_BLOCKS-1:0]      full_vec;
  logic                        accept;

  assign o_kn_ready           = !full_vec[wr_blk];
  assign accept               = i_kn_valid && o_kn_ready;
  assign o_fifo_KN_data_empty = |empty_vec;

  always_comb begin
    push_vec = '0;
    if (accept) begin
      push_vec[wr_blk] = 1'b1;
    end
  end

  // A tile's last row restarts the rotation at FIFO 0 for the next tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_blk <= '0;
    end else if (accept) begin
      if (i_kn_last || (wr_blk == LOG2_PARA_BLOCKS'(PARA_BLOCKS - 1))) begin
        wr_blk <= '0;
      end else begin
        wr_blk <= wr_blk + LOG2_PARA_BLOCKS'(1);
      end
    end
  end

  for (genvar b = 0; b < PARA_BLOCKS; b++) begin : g_slice
    kn_fifo_slice #(
      .W          (ROW_W),
      .DEPTH      (DEPTH),
      .LOG2_DEPTH (LOG2_DEPTH)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .push    (push_vec[b]),
      .wr_data (i_kn_data),
      .pop     (i_fifo_KN_rd_en[b]),
      .rd_data (o_fifo_KN_data_out[b*ROW_W +: ROW_W]),
      .empty   (empty_vec[b]),
      .full    (full_vec[b]),
      .count   (o_fill_level[b*FW +: FW])
    );
  end

`ifdef KN_FIFO_BANK_ERR_EN
  logic [7:0] stall_cnt;

  // Bit1 fires on the 256th consecutive cycle of valid-without-ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err     <= '0;
      stall_cnt <= '0;
    end else begin
      if (|(i_fifo_KN_rd_en & empty_vec)) begin
        o_err[0] <= 1'b1;
      end
      if (i_kn_valid && !o_kn_ready) begin
        if (stall_cnt == 8'hff) begin
          o_err[1] <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 8'd1;
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/kn_fifo_bank.md
KN_FIFO_BANK -- requirements
Module: kn_fifo_bank

Interface
REQ-001 SHALL have parameter NUM_PES, default 16, PEs per PEG.
REQ-002 SHALL have parameter DATA_TYPE, default 16, bits per element.
REQ-003 SHALL have parameter PARA_BLOCKS, default 4, number of parallel KN FIFOs.
REQ-004 SHALL have parameter LOG2_PARA_BLOCKS, default 2, clog2(PARA_BLOCKS).
REQ-005 SHALL have parameter DEPTH, default 16, entries per FIFO, power of two.
REQ-006 SHALL have parameter LOG2_DEPTH, default 4, log2(DEPTH).
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-009 SHALL have port i_kn_valid, input, 1, upstream KN row valid.
REQ-010 SHALL have port i_kn_data, input, DATA_TYPE*NUM_PES, one KN row.
REQ-011 SHALL have port i_kn_last, input, 1, last row of a KN tile.
REQ-012 SHALL have port o_kn_ready, output, 1, bank accepts i_kn_data.
REQ-013 SHALL have port i_fifo_KN_rd_en, input, PARA_BLOCKS, per-FIFO pop from the broadcast stage.
REQ-014 SHALL have port o_fifo_KN_data_out, output, PARA_BLOCKS*DATA_TYPE*NUM_PES, head word of FIFO b at slice b.
REQ-015 SHALL have port o_fifo_KN_data_empty, output, 1, OR of all per-FIFO empties.
REQ-016 SHALL have port o_fill_level, output, PARA_BLOCKS*(LOG2_DEPTH+1), occupancy per FIFO.

Function
REQ-017 Write pointer wr_blk SHALL select the target FIFO and reset to 0.
REQ-018 A beat SHALL be accepted iff i_kn_valid and o_kn_ready are both high in the same cycle.
REQ-019 o_kn_ready SHALL be high iff FIFO wr_blk is not full, using registered occupancy.
REQ-020 On acceptance, wr_blk SHALL advance by 1, wrapping PARA_BLOCKS-1 -> 0.
REQ-021 On acceptance with i_kn_last high, wr_blk SHALL go to 0 regardless of its position.
REQ-022 FIFOs SHALL be first-word-fall-through: a word written at cycle N is visible on its slice, and counted in empty/fill, at cycle N+1.
REQ-023 While FIFO b is empty, its slice of o_fifo_KN_data_out SHALL be 0.
REQ-024 i_fifo_KN_rd_en[b] SHALL pop FIFO b only when b is non-empty; a pop on an empty FIFO SHALL be ignored.
REQ-025 A simultaneous push and pop on the same non-empty FIFO SHALL both take effect, leaving occupancy unchanged.
REQ-026 A push into a FIFO that is full at the start of the cycle SHALL be impossible, because ready is low; a pop in that cycle does not raise ready in the same cycle.
REQ-027 Read and write pointers SHALL be LOG2_DEPTH bits and wrap modulo DEPTH; occupancy SHALL be LOG2_DEPTH+1 bits, range 0..DEPTH.
REQ-028 o_fifo_KN_data_empty SHALL be 1 if any FIFO is empty, so the downstream stage may pop up to PARA_BLOCKS words in any rotation.

Reset
REQ-029 Reset SHALL clear wr_blk, all pointers and all occupancies.
REQ-030 Reset SHALL drive o_fifo_KN_data_empty=1, o_kn_ready=1, o_fill_level=0 and o_fifo_KN_data_out=0.
REQ-031 A reset asserted mid-tile SHALL discard all stored words; the first post-reset beat SHALL go to FIFO 0.

Configuration
REQ-032 With macro KN_FIFO_BANK_ERR_EN defined, the block SHALL add output o_err[1:0]: bit0 is sticky pop-on-empty, bit1 is sticky i_kn_valid held high while ready is low for 256 consecutive cycles; both clear only on rst.
REQ-033 Without KN_FIFO_BANK_ERR_EN, the o_err port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-034 A shared package kn_pkg SHALL hold the row-width constant (DATA_TYPE*NUM_PES) and the fill-level width function.
REQ-035 Each FIFO SHALL be an instance of sub-module kn_fifo_slice (FWFT, synchronous reset); kn_fifo_bank owns the round-robin, ready, empty and error logic.

Verification
REQ-036 Reset, then 4 beats D0..D3 with PARA_BLOCKS=4 and no reads -> cycle after the 4th beat: empty=0, slice b=Db, each fill_level=1.
REQ-037 5 beats with i_kn_last on beat 2 -> beats land in FIFOs 0,1,0,1,2; fill_level = {0,1,2,2} (FIFO3..0).
REQ-038 Fill FIFO 0 to DEPTH=16 while wr_blk=0 -> o_kn_ready=0; pop FIFO 0 -> ready=1 the next cycle, and the held beat is accepted.
REQ-039 All FIFOs at fill 1, rd_en=4'b0110 -> next cycle fill={1,0,0,1}, empty=1, slices 1 and 2 are 0.
REQ-040 Pop of an empty FIFO 3 -> no pointer change; with KN_FIFO_BANK_ERR_EN, o_err[0]=1 until rst.
REQ-041 Reset mid-tile after 3 beats -> next cycle empty=1 and fill all 0; the next beat lands in FIFO 0.
